// File: rtl/count_arb_pkg.sv
// Shared types and limits for the count_arbiter block.
package count_arb_pkg;

  // Scheduler states; encodings are fixed so they can be matched in waveforms/debug.
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StLoad  = 2'b01,
    StCount = 2'b10,
    StDone  = 2'b11
  } state_e;

  // Supported range for the number of requesters.
  localparam int unsigned NReqMin = 2;
  localparam int unsigned NReqMax = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: lowest set request at or above ptr, with wrap.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned SelW  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SelW-1:0]  ptr,
  output logic [SelW-1:0]  gid_next,
  output logic             any
);

  logic [2*N_REQ-1:0] dbl;
  logic [2*N_REQ-1:0] mask;
  logic [2*N_REQ-1:0] masked;
  logic               found;

  // Doubling the request vector turns the wrap-around search into a plain
  // lowest-set-bit search over the bits at or above ptr.
  always_comb begin
    dbl      = {req, req};
    mask     = '0;
    gid_next = '0;
    found    = 1'b0;
    any      = |req;
    for (int i = 0; i < 2 * int'(N_REQ); i++) begin
      mask[i] = (i >= int'(ptr));
    end
    masked = dbl & mask;
    for (int i = 0; i < 2 * int'(N_REQ); i++) begin
      if (!found && masked[i]) begin
        found    = 1'b1;
        gid_next = (i >= int'(N_REQ)) ? SelW'(i - int'(N_REQ)) : SelW'(i);
      end
    end
  end

endmodule

// File: rtl/count_arbiter.sv
// Round-robin scheduler sharing one counting datapath between N_REQ requesters.
// Optional watchdog abort of long counts: define COUNT_ARB_WATCHDOG_EN.
module count_arbiter
  import count_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned W          = 8,
  parameter int unsigned MAX_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  output logic [N_REQ-1:0]           ack,
  output logic [W-1:0]               result,
  output logic                       err,
  output logic [$clog2(N_REQ)-1:0]   dp_sel,
  output logic                       dp_load,
  output logic                       dp_en,
  output logic                       dp_inc_vector,
  output logic                       dp_inc_counter,
  input  logic                       dp_co,
  input  logic [W-1:0]               dp_count
);

  localparam int unsigned SelW = $clog2(N_REQ);

  state_e          state_q, state_d;
  logic [SelW-1:0] gid_q, gid_d;
  logic [SelW-1:0] ptr_q, ptr_d;
  logic [W-1:0]    result_q, result_d;
  logic [SelW-1:0] pick_gid;
  logic            pick_any;
  logic            wd_expire;

  rr_pick #(
    .N_REQ (N_REQ),
    .SelW  (SelW)
  ) u_pick (
    .req      (req),
    .ptr      (ptr_q),
    .gid_next (pick_gid),
    .any      (pick_any)
  );

`ifdef COUNT_ARB_WATCHDOG_EN
  localparam int unsigned CntW = $clog2(MAX_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q;

  // Counter holds the number of COUNT cycles already completed in this job.
  assign wd_expire = (state_q == StCount) && (cnt_q == CntW'(MAX_CYCLES - 1));

  // Watchdog counter: clear on load, advance each COUNT cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StLoad) begin
      cnt_d = '0;
    end else if (state_q == StCount) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Error flag: set only when the limit hits without carry-out; dp_co wins a tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state_q == StCount) begin
      if (dp_co) begin
        err_q <= 1'b0;
      end else if (wd_expire) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign wd_expire = 1'b0;
  assign err       = 1'b0;
`endif

  // Next-state logic: grant capture, count completion and pointer advance.
  always_comb begin
    state_d  = state_q;
    gid_d    = gid_q;
    ptr_d    = ptr_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          gid_d   = pick_gid;
          state_d = StLoad;
        end
      end
      StLoad: begin
        state_d = StCount;
      end
      StCount: begin
        if (dp_co) begin
          result_d = dp_count;
          state_d  = StDone;
        end else if (wd_expire) begin
          result_d = '0;
          state_d  = StDone;
        end
      end
      StDone: begin
        ptr_d   = (gid_q == SelW'(N_REQ - 1)) ? '0 : gid_q + 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, grant, pointer and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      gid_q    <= '0;
      ptr_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      gid_q    <= gid_d;
      ptr_q    <= ptr_d;
      result_q <= result_d;
    end
  end

  // Datapath controls and ack decoded from the current state.
  always_comb begin
    ack            = '0;
    dp_load        = 1'b0;
    dp_en          = 1'b0;
    dp_inc_vector  = 1'b0;
    dp_inc_counter = 1'b0;
    unique case (state_q)
      StLoad: begin
        dp_load = 1'b1;
      end
      StCount: begin
        dp_en          = 1'b1;
        dp_inc_vector  = 1'b1;
        dp_inc_counter = 1'b1;
      end
      StDone: begin
        ack[gid_q] = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // gid only changes on a fresh grant, so it is already stable through LOAD..DONE.
  assign dp_sel = gid_q;
  assign result = result_q;

endmodule

// File: tb/tb_count_arbiter.sv
// Self-checking bench for count_arbiter with a job-level round-robin reference model.
module tb_count_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] ack;
  logic [W-1:0] result;
  logic         err;
  logic [1:0]   dp_sel;
  logic         dp_load, dp_en, dp_iv, dp_ic, dp_co;
  logic [W-1:0] dp_count;

  int n_cmp = 0;
  int n_bad = 0;
  int ptr_m = 0;

  count_arbiter #(
    .N_REQ      (N),
    .W          (W),
    .MAX_CYCLES (10)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .ack            (ack),
    .result         (result),
    .err            (err),
    .dp_sel         (dp_sel),
    .dp_load        (dp_load),
    .dp_en          (dp_en),
    .dp_inc_vector  (dp_iv),
    .dp_inc_counter (dp_ic),
    .dp_co          (dp_co),
    .dp_count       (dp_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: first pending requester searching upward from the pointer, with wrap.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Runs one job from an IDLE negedge with req already set; ends at the following IDLE negedge.
  task automatic run_job(input int ncnt, input logic [W-1:0] val, input bit drop_mid,
                         input bit expire, output int g, output int sel_obs);
    int           e;
    int           o;
    logic [N-1:0] onehot;
    e = pick(req, ptr_m);
    g = e;
    @(negedge clk);
    sel_obs = int'(dp_sel);
    check("load_strobe", dp_load, 1);
    check("load_sel", dp_sel, e);
    check("load_en", dp_en, 0);
    dp_co = 1'($urandom_range(0, 1));
    for (int k = 1; k <= ncnt; k++) begin
      @(negedge clk);
      check("count_ctl", {dp_en, dp_iv, dp_ic, dp_load}, 4'b1110);
      check("count_ack", ack, 0);
      check("count_sel", dp_sel, e);
      if (k == 1 && drop_mid) req[e] = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        o = int'($urandom_range(0, N - 1));
        if (o != e) req[o] = 1'b1;
      end
      dp_count = (k == ncnt && !expire) ? val : W'($urandom);
      dp_co    = (k == ncnt && !expire);
    end
    @(negedge clk);
    onehot    = '0;
    onehot[e] = 1'b1;
    check("ack", ack, onehot);
    check("result", result, expire ? 0 : val);
    check("err", err, expire);
    check("done_en", dp_en, 0);
    check("done_sel", dp_sel, e);
    dp_co  = 1'($urandom_range(0, 1));
    req[e] = 1'b0;
    ptr_m  = (e + 1) % N;
    @(negedge clk);
    check("idle_ack", ack, 0);
    check("idle_ctl", {dp_load, dp_en}, 0);
  endtask

  initial begin
    int g, s;
    rst      = 1'b1;
    req      = '0;
    dp_co    = 1'b0;
    dp_count = '0;
    repeat (2) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_result", result, 0);
    check("rst_err", err, 0);
    check("rst_dp", {dp_load, dp_en, dp_iv, dp_ic}, 0);
    check("rst_sel", dp_sel, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single job on requester 2, five COUNT cycles.
    req = 4'b0100;
    run_job(5, 8'h2A, 1'b0, 1'b0, g, s);

    // Carry-out in the very first COUNT cycle.
    req = 4'b0001;
    run_job(1, 8'h5C, 1'b0, 1'b0, g, s);

    // Reset in the middle of COUNT aborts without ack and clears the pointer.
    req   = 4'b0010;
    dp_co = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_count", dp_en, 1);
    rst = 1'b1;
    #1;
    check("midrst_ack", ack, 0);
    check("midrst_out", {result, err, dp_load, dp_en, dp_iv, dp_ic, dp_sel}, 0);
    @(negedge clk);
    check("midrst_ack_hold", ack, 0);
    rst   = 1'b0;
    ptr_m = 0;
    req   = 4'b1111;

    // Fairness: all requesting, each re-raises after its ack.
    for (int i = 0; i < 5; i++) begin
      run_job(int'($urandom_range(1, 4)), W'($urandom), 1'b0, 1'b0, g, s);
      check("fair_order", s, i % N);
      req[g] = 1'b1;
    end

    // Requester 1 drops req mid-job; its ack still comes and 2 is served next.
    req = 4'b0110;
    run_job(3, 8'h11, 1'b1, 1'b0, g, s);
    check("drop_gid", s, 1);
    run_job(2, 8'h22, 1'b0, 1'b0, g, s);
    check("after_drop_gid", s, 2);

`ifdef COUNT_ARB_WATCHDOG_EN
    req = 4'b1000;
    run_job(10, 8'h00, 1'b0, 1'b1, g, s);
    req = 4'b1000;
    run_job(10, 8'h77, 1'b0, 1'b0, g, s);
`endif

    // Randomised traffic against the reference model.
    for (int j = 0; j < 40; j++) begin
      req = req | N'($urandom);
      if (req == 0) req[$urandom_range(0, N - 1)] = 1'b1;
      run_job(int'($urandom_range(1, 8)), W'($urandom), ($urandom_range(0, 3) == 0), 1'b0, g, s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
